// File: rtl/tof_pkg.sv
// Shared types and constants for the multi-channel sonar time-of-flight ranger.
// The scale function turns clock rate and speed of sound into a cycles-to-cm constant.
package tof_pkg;

  typedef enum logic [2:0] {IDLE, BLANK, LISTEN, CALC, DONE} tof_state_t;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_CLK_HZ       = 100_000_000;
  localparam int unsigned DEF_SOUND_CM_S   = 34_300;
  localparam int unsigned DEF_MAX_CYCLES   = 500_000;
  localparam int unsigned DEF_BLANK_CYCLES = 2_000;
  localparam int unsigned DEF_CNT_W        = 32;
  localparam int unsigned DEF_RANGE_W      = 16;
  localparam int unsigned DEF_FRAC_W       = 32;

  // Round-to-nearest of sound * 2^frac / (2 * clk); the 2 accounts for the round trip.
  function automatic longint unsigned tof_scale_k(input longint unsigned clk_hz,
                                                  input longint unsigned sound_cm_s,
                                                  input int unsigned     frac_w);
    longint unsigned num;
    num = sound_cm_s << frac_w;
    return (num + clk_hz) / (2 * clk_hz);
  endfunction

endpackage

// File: rtl/tof_range_scaler.sv
// Two-stage pipelined cycles-to-centimetre scaler: multiply by K, then shift and saturate.
// A channel index travels alongside the data so the caller knows where to write the result.
module tof_range_scaler #(
  parameter int unsigned     CNT_W   = 32,
  parameter int unsigned     RANGE_W = 16,
  parameter int unsigned     FRAC_W  = 32,
  parameter int unsigned     IDX_W   = 2,
  parameter longint unsigned K       = 736587
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_valid,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [CNT_W-1:0]   i_tof,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx,
  output logic [RANGE_W-1:0] o_range
);

  localparam int unsigned            PROD_W    = CNT_W + FRAC_W;
  localparam logic [PROD_W-1:0]      K_P       = PROD_W'(K);
  localparam logic [CNT_W-1:0]       RANGE_MAX = CNT_W'({RANGE_W{1'b1}});

  logic              r_s1_valid;
  logic [IDX_W-1:0]  r_s1_idx;
  logic [PROD_W-1:0] r_s1_prod;
  logic [CNT_W-1:0]  w_cm;

  assign w_cm = r_s1_prod[PROD_W-1:FRAC_W];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      o_valid    <= r_s1_valid;
    end
  end

  // NOTE: the data path is not reset; only the valid bits qualify it, which keeps reset fan-out small.
  always_ff @(posedge clk_in) begin
    r_s1_idx  <= i_idx;
    r_s1_prod <= PROD_W'(i_tof) * K_P;
    o_idx     <= r_s1_idx;
    o_range   <= (w_cm > RANGE_MAX) ? RANGE_W'(RANGE_MAX) : w_cm[RANGE_W-1:0];
  end

endmodule

// File: rtl/tof_multi_ranger.sv
// Multi-channel sonar ranger: one shared counter times the first echo per channel after a ping,
// with ringdown blanking and a listen timeout, then scales each hit to centimetres.
module tof_multi_ranger
  import tof_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned SOUND_CM_S   = DEF_SOUND_CM_S,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned RANGE_W      = DEF_RANGE_W,
  parameter int unsigned FRAC_W       = DEF_FRAC_W
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      trigger_in,
  input  logic [NUM_CH-1:0]         echo_in,
  output logic                      busy_out,
  output logic [NUM_CH*RANGE_W-1:0] range_out,
  output logic [NUM_CH-1:0]         hit_out,
  output logic [NUM_CH*CNT_W-1:0]   tof_out,
  output logic                      valid_out
);

  localparam longint unsigned  K       = tof_scale_k(CLK_HZ, SOUND_CM_S, FRAC_W);
  localparam int unsigned      IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned      CC_W    = $clog2(NUM_CH + 2);
  localparam logic [CNT_W-1:0] BLANK_N = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_CYCLES);

  tof_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]  r_hit;
  logic [CNT_W-1:0]   r_tof   [NUM_CH];
  logic [RANGE_W-1:0] r_range [NUM_CH];
  logic [CC_W-1:0]    r_calc;
  logic               r_busy;
  logic               r_valid;

  logic [CNT_W-1:0]   w_n;
  logic [NUM_CH-1:0]  w_new_hit;
  logic [NUM_CH-1:0]  w_hit_next;
  logic               w_issue_valid;
  logic [IDX_W-1:0]   w_issue_idx;
  logic               w_sc_valid;
  logic [IDX_W-1:0]   w_sc_idx;
  logic [RANGE_W-1:0] w_sc_range;

  // w_n is the count that the upcoming edge represents, so captures and exits compare against it.
  assign w_n           = r_cnt + CNT_W'(1);
  assign w_new_hit     = echo_in & ~r_hit;
  assign w_hit_next    = r_hit | w_new_hit;
  assign w_issue_valid = (r_state == CALC) && (r_calc < CC_W'(NUM_CH));
  assign w_issue_idx   = r_calc[IDX_W-1:0];

  tof_range_scaler #(
    .CNT_W  (CNT_W),
    .RANGE_W(RANGE_W),
    .FRAC_W (FRAC_W),
    .IDX_W  (IDX_W),
    .K      (K)
  ) u_scaler (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_valid(w_issue_valid),
    .i_idx  (w_issue_idx),
    .i_tof  (r_tof[w_issue_idx]),
    .o_valid(w_sc_valid),
    .o_idx  (w_sc_idx),
    .o_range(w_sc_range)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hit   <= '0;
      r_calc  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_tof[i]   <= '0;
        r_range[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (trigger_in) begin
          r_state <= BLANK;
          r_cnt   <= '0;
          r_hit   <= '0;
          r_busy  <= 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            r_tof[i]   <= '0;
            r_range[i] <= '0;
          end
        end
        BLANK: begin
          r_cnt <= w_n;
          if (w_n == BLANK_N) r_state <= LISTEN;
        end
        LISTEN: begin
          r_cnt <= w_n;
          r_hit <= w_hit_next;
          for (int i = 0; i < NUM_CH; i++)
            if (w_new_hit[i]) r_tof[i] <= w_n;
          if ((&w_hit_next) || (w_n == MAX_N)) begin
            r_state <= CALC;
            r_calc  <= '0;
          end
        end
        CALC: begin
          r_calc <= r_calc + CC_W'(1);
          if (r_calc == CC_W'(NUM_CH + 1)) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_sc_valid) r_range[w_sc_idx] <= r_hit[w_sc_idx] ? w_sc_range : '0;
    end
  end

  always_comb begin
    // NOTE: defaults first so every bit is assigned on every pass and no latch is inferred.
    range_out = '0;
    tof_out   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      range_out[i*RANGE_W +: RANGE_W] = r_range[i];
      tof_out[i*CNT_W +: CNT_W]       = r_tof[i];
    end
  end

  assign hit_out   = r_hit;
  assign busy_out  = r_busy;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_tof_multi_ranger.sv
// Randomized and directed scoreboard bench for tof_multi_ranger with a scaled-down clock
// so that full listen windows stay short; a monitor pops expected results on valid_out.
`timescale 1ns/1ps
module tb_tof_multi_ranger;

  localparam int NUM_CH = 4;
  localparam int CLK_HZ = 100_000;
  localparam int SOUND  = 34_300;
  localparam int MAXC   = 3000;
  localparam int BLANK  = 100;
  localparam int CNT_W  = 32;
  localparam int RNG_W  = 8;
  localparam int FRAC_W = 32;

  typedef struct {
    logic [NUM_CH-1:0]       hit;
    logic [NUM_CH*CNT_W-1:0] tof;
    logic [NUM_CH*RNG_W-1:0] rng;
    int                      cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_in = 1'b1;
  logic                    trigger_in = 1'b0;
  logic [NUM_CH-1:0]       echo_in = '0;
  logic                    busy_out, valid_out;
  logic [NUM_CH*RNG_W-1:0] range_out;
  logic [NUM_CH-1:0]       hit_out;
  logic [NUM_CH*CNT_W-1:0] tof_out;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  int   sched [NUM_CH][3];
  longint k_scale;

  tof_multi_ranger #(
    .NUM_CH(NUM_CH), .CLK_HZ(CLK_HZ), .SOUND_CM_S(SOUND), .MAX_CYCLES(MAXC),
    .BLANK_CYCLES(BLANK), .CNT_W(CNT_W), .RANGE_W(RNG_W), .FRAC_W(FRAC_W)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .trigger_in(trigger_in), .echo_in(echo_in),
    .busy_out(busy_out), .range_out(range_out), .hit_out(hit_out),
    .tof_out(tof_out), .valid_out(valid_out)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Physical rule: distance = tof * speed / (2 * clk), expressed with the real-valued K.
  function automatic int unsigned model_range(input int tof);
    longint unsigned cm;
    cm = (longint'(tof) * k_scale) >> FRAC_W;
    return (cm > 255) ? 255 : int'(cm);
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 3; j++) sched[c][j] = -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  busy_out,  0);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_hit"},   hit_out,   0);
    check({tag, "_tof"},   tof_out,   0);
    check({tag, "_range"}, range_out, 0);
  endtask

  task automatic run_meas(input int trig_k, input int rst_k);
    int   first [NUM_CH];
    int   exit_n, e0, limit, t;
    bit   all_hit;
    exp_t e;
    all_hit = 1;
    exit_n  = 0;
    e.hit = '0; e.tof = '0; e.rng = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      first[c] = -1;
      for (int j = 0; j < 3; j++) begin
        t = sched[c][j];
        if (t >= BLANK && t <= MAXC && (first[c] < 0 || t < first[c])) first[c] = t;
      end
      if (first[c] < 0) all_hit = 0;
      else if (first[c] > exit_n) exit_n = first[c];
    end
    if (!all_hit) exit_n = MAXC;
    for (int c = 0; c < NUM_CH; c++)
      if (first[c] >= 0) begin
        e.hit[c] = 1'b1;
        e.tof[c*CNT_W +: CNT_W] = first[c];
        e.rng[c*RNG_W +: RNG_W] = RNG_W'(model_range(first[c]));
      end
    @(negedge clk);
    e0 = cyc + 1;
    e.cyc = e0 + exit_n + NUM_CH + 2;
    if (rst_k < 0) sb_q.push_back(e);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    check("clear_busy", busy_out, 1);
    check("clear_hit", hit_out, 0);
    check("clear_tof_range", {tof_out, range_out}, 0);
    limit = (rst_k >= 0) ? rst_k : exit_n + NUM_CH + 3;
    for (int k = 1; k <= limit; k++) begin
      echo_in = '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < 3; j++)
          if (sched[c][j] == k) echo_in[c] = 1'b1;
      trigger_in = (k == trig_k);
      rst_in     = (k == rst_k);
      @(negedge clk);
    end
    echo_in = '0; trigger_in = 1'b0;
    if (rst_in) begin
      rst_in = 1'b0;
      check_zero("abort");
    end
    for (int i = 0; i < 20 && busy_out; i++) @(negedge clk);
    if (busy_out) begin
      n_checks++; n_errors++;
      $display("FAIL busy_timeout: got busy=1 required busy=0 within 20 cycles");
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d required no pulse", cyc);
        end else begin
          e = sb_q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          check("hit", hit_out, e.hit);
          check("tof", tof_out, e.tof);
          check("range", range_out, e.rng);
          check("busy_at_valid", busy_out, 1);
        end
        @(negedge clk);
        check("busy_after_valid", busy_out, 0);
        check("valid_one_cycle", valid_out, 0);
      end
    end
  end

  initial begin : stim
    k_scale = longint'(real'(SOUND) * (2.0 ** FRAC_W) / (2.0 * real'(CLK_HZ)));
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    check_zero("reset");

    // single hit then timeout
    clear_sched(); sched[0][0] = 1000;
    run_meas(-1, -1);
    // staggered hits, early exit on the last one
    clear_sched(); sched[0][0] = 200; sched[1][0] = 400; sched[2][0] = 600; sched[3][0] = 800;
    run_meas(-1, -1);
    // blanking edges and first-echo-only
    clear_sched();
    sched[2][0] = 50; sched[2][1] = 300;
    sched[1][0] = 500; sched[1][1] = 510;
    sched[0][0] = BLANK - 1; sched[0][1] = BLANK;
    run_meas(-1, -1);
    // echo exactly at the window end, one just past it
    clear_sched(); sched[3][0] = MAXC; sched[0][0] = MAXC + 1; sched[1][0] = MAXC - 1;
    run_meas(-1, -1);
    // simultaneous echoes
    clear_sched();
    for (int c = 0; c < NUM_CH; c++) sched[c][0] = 500;
    run_meas(-1, -1);
    // saturation around the 255 cm limit
    clear_sched(); sched[0][0] = 2000; sched[1][0] = 1487; sched[2][0] = 1493; sched[3][0] = 1480;
    run_meas(-1, -1);
    // trigger while busy (mid-listen and during the valid cycle) is ignored
    clear_sched(); sched[0][0] = 300; sched[1][0] = 310; sched[2][0] = 320; sched[3][0] = 330;
    run_meas(50, -1);
    run_meas(330 + NUM_CH + 3, -1);
    // reset mid-measurement aborts, then a normal measurement follows
    clear_sched(); sched[0][0] = 200;
    run_meas(-1, 700);
    clear_sched(); sched[1][0] = 250; sched[2][0] = 260; sched[0][0] = 270; sched[3][0] = 280;
    run_meas(-1, -1);

    for (int r = 0; r < 8; r++) begin
      clear_sched();
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < 3; j++)
          sched[c][j] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, MAXC + 200));
      run_meas(int'($urandom_range(1, 400)), -1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
